// File: rtl/jk_cnt_pkg.sv
// Shared types and terminal-value helpers for the JK-based modulo counter.
package jk_cnt_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  localparam int unsigned ZERO = 0;

  function automatic int unsigned cnt_max(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/jk_cnt_stage.sv
// One JK flip-flop state bit with asynchronous active-low clear.
module jk_cnt_stage (
  input  logic clk,
  input  logic cr,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    case ({j, k})
      2'b10:   q_d = 1'b1;
      2'b01:   q_d = 1'b0;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK stages with load, enable, tc and wrap.
// Define JK_CNT_SATURATE_EN to hold at the terminal values instead of wrapping.
module jk_mod_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             cr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(cnt_max(MODULUS));
  localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(ZERO);
  localparam logic [WIDTH:0]   MOD_V  = (WIDTH + 1)'(MODULUS);

  cnt_dir_e         dir;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             upd;
  logic             at_term;
  logic             tc_c;
  logic             wrap_d;
  logic             wrap_q;

  assign dir = cnt_dir_e'(up);

  always_comb begin
    at_term = (dir == CNT_UP) ? (cnt == MAX_V) : (cnt == ZERO_V);
    tc_c    = en & ~load & at_term;
    nxt     = cnt;
    upd     = 1'b0;
    if (load) begin
      upd = 1'b1;
      nxt = ({1'b0, d} < MOD_V) ? d : MAX_V;
    end else if (en) begin
      upd = 1'b1;
      if (at_term) begin
`ifdef JK_CNT_SATURATE_EN
        nxt = cnt;
`else
        nxt = (dir == CNT_UP) ? ZERO_V : MAX_V;
`endif
      end else if (dir == CNT_UP) begin
        // An out-of-range count (only possible without a full binary range) recovers to zero.
        nxt = (cnt > MAX_V) ? ZERO_V : cnt + 1'b1;
      end else begin
        nxt = cnt - 1'b1;
      end
    end
    j = {WIDTH{upd}} & nxt;
    k = {WIDTH{upd}} & ~nxt;
  end

`ifdef JK_CNT_SATURATE_EN
  assign wrap_d = 1'b0;
`else
  assign wrap_d = tc_c;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_cnt_stage u_stage (
      .clk (clk),
      .cr  (cr),
      .j   (j[i]),
      .k   (k[i]),
      .q   (cnt[i])
    );
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign q    = cnt;
  assign tc   = tc_c;
  assign wrap = wrap_q;

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-N up/down counter whose state bits are JK flip-flop stages driven by excitation logic. It sits downstream of the JK flip-flop cell, consuming it as its storage element. It is the counting stage for the lab's sequential designs, with parallel load, enable, direction, terminal-count and wrap outputs.

## Interface
- WIDTH, 4, number of state bits / JK stages
- MODULUS, 10, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH
- clk  input  1  rising-edge clock
- cr  input  1  asynchronous active-low clear
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load, priority over en
- d  input  WIDTH  load value
- q  output  WIDTH  current count
- tc  output  1  terminal count, combinational
- wrap  output  1  registered one-cycle pulse after a wrap

## Operation
- One clock; reset is asynchronous and active-low.
- cr low forces q = 0 and wrap = 0 immediately, regardless of clk. Both outputs hold those values while cr is low.
- The next-state value n is resolved in priority order at each rising edge with cr high:
  - load = 1: n = d if d < MODULUS, else n = MODULUS-1 (clamped). en and up are ignored.
  - load = 0, en = 0: hold. All stages get J = K = 0.
  - load = 0, en = 1, up = 1: n = q+1, or n = 0 when q == MODULUS-1.
  - load = 0, en = 1, up = 0: n = q-1, or n = MODULUS-1 when q == 0.
- Each bit i is driven with JK excitation J_i = n_i and K_i = ~n_i when updating, and J_i = K_i = 0 when holding.
- tc = en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)).
- wrap is registered. It is 1 for exactly the cycle after an edge on which a wrap transition (terminal to opposite end) occurred, and 0 otherwise.
- A load never produces a wrap, even when it moves q from one end of the range to the other.
- If q is out of range (possible only when MODULUS < 2**WIDTH and there is no load): counting up returns q to 0; counting down gives q-1 with no wrap. This case is unreachable in normal operation.

## Timing
- q updates one clock after the qualifying edge, so load-to-output and count-to-output latency is 1 cycle.
- tc is combinational from q, en, up and load, with zero latency. It is valid in the same cycle as the edge that will wrap.
- wrap asserts in the cycle after tc was sampled high at an edge and lasts one cycle. With continuous counting and MODULUS = 2, tc and wrap are high on alternating cycles.
- load and en high together: the load wins, tc = 0, and wrap = 0 next cycle.
- Direction change at the terminal value: the sampled up selects the behaviour. For example, at q = MODULUS-1 with up = 0, the counter decrements with no tc.
- cr asserted mid-count: q and wrap clear asynchronously. The first edge after cr deasserts evaluates from q = 0.

## Configuration
- JK_CNT_SATURATE_EN
  - Defined: at a terminal value the counter holds instead of wrapping. Counting up sticks at MODULUS-1 and counting down sticks at 0. tc is still asserted there, and wrap is tied to 0.
  - Undefined: modulo wrap behaviour as described above.

## Structure
- Shared package jk_cnt_pkg holds:
  - localparam helpers for the terminal values (MAX = MODULUS-1, ZERO)
  - a typedef for the direction encoding (CNT_DOWN = 0, CNT_UP = 1)
- One sub-module, jk_cnt_stage: a single JK bit with asynchronous active-low clear, ports clk, cr, j, k, q.
  - The counter instantiates it WIDTH times in a generate loop.
  - Next-state and excitation logic live in jk_mod_counter.

## Test plan
- Reset: cr low for 3 cycles with en = 1 and load = 1 -> q = 0 and wrap = 0 throughout, applied asynchronously between edges.
- Up wrap, MODULUS = 10: en = 1, up = 1 from 0 for 12 edges -> q runs 0..9, 0, 1. tc is high while q = 9. wrap is high for the single cycle when q = 0 after 9.
- Down wrap: load d = 0, then en = 1, up = 0 -> q goes 9, 8. tc is high at q = 0, then wrap pulses once.
- Load priority and clamp: load = 1, en = 1, d = 13 -> q = 9 next cycle, tc = 0, wrap = 0. Then d = 5 -> q = 5.
- Hold and mid-count clear: en = 0 for 4 cycles at q = 6 -> q stays 6. Pulse cr low at q = 7 -> q = 0 at once, and counting resumes 1, 2.
- JK_CNT_SATURATE_EN defined: counting up from 8 -> q = 9, 9, 9 with tc = 1 and wrap = 0. Counting down from 1 -> 0, 0.
